// File: rtl/dvi_timing_pkg.sv
// rtl/dvi_timing_pkg.sv - shared constants for the DVI timing/pattern generator
//
// Purpose: pattern mode encodings, default 640x480@60 raster geometry,
// counter widths and the colour-bar table.
// Ports: none (package).
package dvi_timing_pkg;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRID  = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  // {r,g,b} on/off flags per bar; index 0 is the leftmost bar.
  // Order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/dvi_timing_counter.sv
// rtl/dvi_timing_counter.sv - raster h/v counters with visible, sync and end-of-frame decode
//
// Purpose: free-running pixel/line counters and combinational decode of
// the current counter state.
// Ports:
//   pixclk_i     pixel clock
//   reset_i      synchronous active-high reset, clears both counters
//   h_cnt_o      current pixel in line, 0..H_TOTAL-1
//   v_cnt_o      current line in frame, 0..V_TOTAL-1
//   h_vis_o      h_cnt_o inside the visible columns (any line)
//   visible_o    inside the visible area
//   hsync_act_o  inside the horizontal sync pulse (polarity-free)
//   vsync_act_o  inside the vertical sync pulse (polarity-free)
//   eof_o        last pixel of the frame
module dvi_timing_counter
  import dvi_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic           pixclk_i,
  input  logic           reset_i,
  output logic [X_W-1:0] h_cnt_o,
  output logic [Y_W-1:0] v_cnt_o,
  output logic           h_vis_o,
  output logic           visible_o,
  output logic           hsync_act_o,
  output logic           vsync_act_o,
  output logic           eof_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS_C  = X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_VISIBLE + H_FRONT);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_VIS_C  = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_VISIBLE + V_FRONT);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_chk_total
    $error("raster totals exceed the counter widths");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_chk_sync
    $error("sync widths must be at least 1");
  end

  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  logic           h_last, v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q + X_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + Y_W'(1);
    end
  end

  always_ff @(posedge pixclk_i) begin
    if (reset_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign h_vis_o     = (h_cnt_q < H_VIS_C);
  assign visible_o   = h_vis_o && (v_cnt_q < V_VIS_C);
  assign hsync_act_o = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
  assign vsync_act_o = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
  assign eof_o       = h_last && v_last;

endmodule

// File: rtl/dvi_pattern_timing.sv
// rtl/dvi_pattern_timing.sv - DVI raster timing and test-pattern generator
//
// Purpose: drives registered RGB, syncs and data-enable for the TMDS path,
// with four runtime-selectable test patterns.
// Ports:
//   pixclk_i         pixel clock
//   reset_i          synchronous active-high reset
//   mode_i           pattern select, taken at end of frame
//   red_o/green_o/blue_o  pixel colour, COLOR_BITS each
//   hsync_o/vsync_o  syncs at the configured polarity
//   de_o             visible-area enable
//   x_o/y_o          visible column/row, 0 in blanking
//   frame_start_o    pulse with pixel (0,0)
//   frame_count_o    completed-frame counter
module dvi_pattern_timing
  import dvi_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 8
) (
  input  logic                  pixclk_i,
  input  logic                  reset_i,
  input  logic [1:0]            mode_i,
  output logic [COLOR_BITS-1:0] red_o,
  output logic [COLOR_BITS-1:0] green_o,
  output logic [COLOR_BITS-1:0] blue_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [X_W-1:0]        x_o,
  output logic [Y_W-1:0]        y_o,
  output logic                  frame_start_o,
  output logic [7:0]            frame_count_o
);

  if (H_VISIBLE % 8 != 0) begin : g_chk_hvis
    $error("H_VISIBLE must be a multiple of 8");
  end
  if (COLOR_BITS < 1 || COLOR_BITS > 8) begin : g_chk_cbits
    $error("COLOR_BITS must be in 1..8");
  end

  localparam logic [X_W-1:0] BAR_LAST   = X_W'(H_VISIBLE / 8 - 1);
  localparam logic [X_W-1:0] H_VIS_LAST = X_W'(H_VISIBLE - 1);
  localparam logic [Y_W-1:0] V_VIS_LAST = Y_W'(V_VISIBLE - 1);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           h_vis, visible, hs_act, vs_act, eof;

  dvi_timing_counter #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_cnt (
    .pixclk_i    (pixclk_i),
    .reset_i     (reset_i),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .h_vis_o     (h_vis),
    .visible_o   (visible),
    .hsync_act_o (hs_act),
    .vsync_act_o (vs_act),
    .eof_o       (eof)
  );

  logic [1:0]     mode_q;
  logic [7:0]     frame_cnt_q;
  logic [2:0]     bar_idx_q;
  logic [X_W-1:0] bar_pix_q;

  always_ff @(posedge pixclk_i) begin
    if (reset_i) begin
      mode_q      <= MODE_BARS;
      frame_cnt_q <= '0;
      bar_idx_q   <= '0;
      bar_pix_q   <= '0;
    end else begin
      if (eof) begin
        mode_q      <= mode_i;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      // Bar counters track h_cnt through the visible columns and park at
      // zero in blanking, so they are already aligned when x returns to 0.
      if (!h_vis) begin
        bar_pix_q <= '0;
        bar_idx_q <= '0;
      end else if (bar_pix_q == BAR_LAST) begin
        bar_pix_q <= '0;
        bar_idx_q <= bar_idx_q + 3'd1;
      end else begin
        bar_pix_q <= bar_pix_q + X_W'(1);
      end
    end
  end

  logic [2:0]            rgb_on;
  logic                  grid_on, check_on;
  logic [COLOR_BITS-1:0] r_d, g_d, b_d;

  assign grid_on  = (h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0) ||
                    (h_cnt == H_VIS_LAST) || (v_cnt == V_VIS_LAST);
  assign check_on = h_cnt[4] ^ v_cnt[4] ^ frame_cnt_q[5];

  always_comb begin
    case (mode_q)
      MODE_BARS:  rgb_on = BAR_RGB[bar_idx_q];
      MODE_GRID:  rgb_on = {3{grid_on}};
      MODE_CHECK: rgb_on = {3{check_on}};
      default:    rgb_on = 3'b000;
    endcase
    r_d = {COLOR_BITS{rgb_on[2]}};
    g_d = {COLOR_BITS{rgb_on[1]}};
    b_d = {COLOR_BITS{rgb_on[0]}};
    if (mode_q == MODE_GRAD) begin
      r_d = h_cnt[COLOR_BITS-1:0];
      g_d = v_cnt[COLOR_BITS-1:0];
      b_d = frame_cnt_q[7 -: COLOR_BITS];
    end
    if (!visible) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Every output is registered from the same counter state, so they share
  // one cycle of latency and stay aligned with each other.
  always_ff @(posedge pixclk_i) begin
    if (reset_i) begin
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      frame_start_o <= 1'b0;
      frame_count_o <= '0;
    end else begin
      red_o         <= r_d;
      green_o       <= g_d;
      blue_o        <= b_d;
      hsync_o       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_o       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      de_o          <= visible;
      x_o           <= visible ? h_cnt : '0;
      y_o           <= visible ? v_cnt : '0;
      frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
      frame_count_o <= frame_cnt_q;
    end
  end

endmodule

// File: tb/tb_dvi_pattern_timing.sv
// tb/tb_dvi_pattern_timing.sv - scoreboard bench for dvi_pattern_timing on a reduced raster
module tb_dvi_pattern_timing;

  // 16x8 visible, 20x12 total, 240-cycle frames; hsync active-high.
  localparam int W  = 31;
  localparam int FP = 240;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [4:0]  red_o, green_o, blue_o;
  logic        hsync_o, vsync_o, de_o, frame_start_o;
  logic [10:0] x_o;
  logic [9:0]  y_o;
  logic [7:0]  frame_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int fc;
    int x;
    int y;
    int rgb;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  dvi_pattern_timing #(
    .H_VISIBLE(16), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .COLOR_BITS(5)
  ) dut (
    .pixclk_i      (clk),
    .reset_i       (rst),
    .mode_i        (mode),
    .red_o         (red_o),
    .green_o       (green_o),
    .blue_o        (blue_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .de_o          (de_o),
    .x_o           (x_o),
    .y_o           (y_o),
    .frame_start_o (frame_start_o),
    .frame_count_o (frame_count_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int fc, input int x, input int y,
                      input int r, input int g, input int b);
    exp_t e;
    e.fc  = fc;
    e.x   = x;
    e.y   = y;
    e.rgb = (r << 10) | (g << 5) | b;
    sb_q.push_back(e);
  endtask

  task automatic go(inout int j, input int t);
    while (j < t) begin
      @(negedge clk);
      j++;
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    int  per, de_cnt, hs_cnt, vs_cnt, vs_first, since_de, hs_run, exp_fc;
    bit  have_fs, prev_rst, prev_de, prev_hs, hs_act, vs_act;
    exp_t e;
    per = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_first = -1;
    since_de = 1000; hs_run = 0; exp_fc = 0;
    have_fs = 0; prev_rst = 1; prev_de = 0; prev_hs = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_rgb", int'({red_o, green_o, blue_o}), 0);
        chk("rst_de", int'(de_o), 0);
        chk("rst_xy", int'({x_o, y_o}), 0);
        chk("rst_frame_start", int'(frame_start_o), 0);
        chk("rst_hsync", int'(hsync_o), 0);
        chk("rst_vsync", int'(vsync_o), 1);
        chk("rst_frame_count", int'(frame_count_o), 0);
        have_fs = 0; exp_fc = 0; prev_de = 0; prev_hs = 0;
        since_de = 1000; hs_run = 0;
      end else begin
        if (prev_rst) chk("first_pixel_frame_start", int'(frame_start_o), 1);
        if (frame_start_o) begin
          chk("fs_de", int'(de_o), 1);
          chk("fs_xy", int'({x_o, y_o}), 0);
          chk("fs_frame_count", int'(frame_count_o), exp_fc);
          exp_fc = (exp_fc + 1) % 256;
          if (have_fs) begin
            chk("frame_period", per, FP);
            chk("de_cycles", de_cnt, 128);
            chk("hsync_cycles", hs_cnt, 24);
            chk("vsync_cycles", vs_cnt, 40);
            chk("vsync_offset", vs_first, 180);
          end
          have_fs = 1; per = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_first = -1;
        end
        hs_act = (hsync_o == 1'b1);
        vs_act = (vsync_o == 1'b0);
        if (vs_act && vs_first < 0) vs_first = per;
        if (de_o) de_cnt++;
        if (hs_act) hs_cnt++;
        if (vs_act) vs_cnt++;
        if (!de_o) begin
          chk("blank_rgb", int'({red_o, green_o, blue_o}), 0);
          chk("blank_xy", int'({x_o, y_o}), 0);
        end
        if (de_o && !prev_de) begin
          if (y_o != 0) chk("line_period", since_de, 20);
          since_de = 0;
        end
        if (hs_act && !prev_hs && since_de < 20) chk("hsync_offset", since_de, 17);
        if (hs_act) hs_run++;
        else if (prev_hs) begin
          chk("hsync_width", hs_run, 2);
          hs_run = 0;
        end
        if (de_o && sb_q.size() > 0) begin
          if (int'(frame_count_o) == sb_q[0].fc && int'(x_o) == sb_q[0].x &&
              int'(y_o) == sb_q[0].y) begin
            e = sb_q.pop_front();
            chk($sformatf("pixel f%0d (%0d,%0d) rgb", e.fc, e.x, e.y),
                int'({red_o, green_o, blue_o}), e.rgb);
          end
        end
        per++;
        since_de++;
        prev_de = de_o;
        prev_hs = hs_act;
      end
      prev_rst = rst;
    end
  end

  initial begin : stim
    int j;
    int r;
    repeat (4) @(negedge clk);
    // frame 0: colour bars, two pixels per bar
    push(0, 0, 0, W, W, W);   push(0, 1, 0, W, W, W);
    push(0, 2, 0, W, W, 0);   push(0, 4, 0, 0, W, W);
    push(0, 14, 0, 0, 0, 0);  push(0, 8, 1, W, 0, W);
    push(0, 10, 2, W, 0, 0);  push(0, 6, 3, 0, W, 0);
    push(0, 12, 5, 0, 0, W);  push(0, 15, 7, 0, 0, 0);
    // frame 1: grid
    push(1, 0, 0, W, W, W);   push(1, 5, 0, W, W, W);
    push(1, 15, 3, W, W, W);  push(1, 0, 5, W, W, W);
    push(1, 5, 5, 0, 0, 0);   push(1, 7, 6, 0, 0, 0);
    push(1, 3, 7, W, W, W);
    // frame 2: gradient
    push(2, 3, 0, 3, 0, 0);   push(2, 9, 4, 9, 4, 0);
    push(2, 15, 7, 15, 7, 0);
    // checker, inverts at frame 32
    push(3, 0, 0, 0, 0, 0);   push(3, 9, 4, 0, 0, 0);
    push(31, 5, 2, 0, 0, 0);  push(32, 0, 0, W, W, W);
    push(32, 15, 7, W, W, W); push(33, 4, 4, W, W, W);
    // gradient again, blue from frame_count[7:3], across the wrap
    push(34, 7, 2, 7, 2, 4);  push(200, 10, 6, 10, 6, 25);
    push(255, 15, 7, 15, 7, 31);
    push(0, 1, 1, 1, 1, 0);

    rst = 1'b0;
    j = 0;
    go(j, 60);       mode = 2'd1;
    go(j, 300);      mode = 2'd2;
    go(j, 540);      mode = 2'd3;
    go(j, 33 * FP + 60); mode = 2'd2;

    // reset mid-line in frame 256 (row 4, column 9)
    go(j, 256 * FP + 4 * 20 + 9);
    rst = 1'b1;
    go(j, 256 * FP + 4 * 20 + 12);
    rst = 1'b0;
    r = j;
    push(0, 2, 0, W, W, 0);   push(0, 8, 1, W, 0, W);

    // reset coinciding with the end-of-frame edge
    go(j, r + FP - 1);
    rst = 1'b1;
    go(j, r + FP + 1);
    rst = 1'b0;
    r = j;
    push(0, 2, 0, W, W, 0);   push(0, 6, 3, 0, W, 0);
    go(j, r + FP + 60);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvi_pattern_timing.md
# dvi_pattern_timing

Parametrised video timing and test-pattern generator for the DVI/HDMI output path. It runs in the pixel clock domain and produces registered RGB, hsync, vsync and data-enable for the per-channel TMDS encoders and serialisers. It replaces the fixed 640x480 single-pattern generator with configurable raster geometry, sync polarity, colour depth and four runtime-selectable patterns.

## Interface
- H_VISIBLE, 640: active pixels per line; must be a multiple of 8
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync widths, in pixels
- V_VISIBLE, 480: active lines per frame
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync widths, in lines
- HSYNC_POL, 0 / VSYNC_POL, 0: active sync level (0 = active-low)
- COLOR_BITS, 8: bits per colour channel; legal range 1..8
- pixclk  in  1  pixel clock; the block's only clock
- reset  in  1  synchronous, active-high
- mode  in  2  pattern select; sampled only at end of frame
- red, green, blue  out  COLOR_BITS each  pixel colour
- hsync, vsync  out  1  sync outputs at the configured polarity
- de  out  1  high during the visible area
- x  out  11  visible column; 0 during blanking
- y  out  10  visible row; 0 during blanking
- frame_start  out  1  one-cycle pulse coinciding with pixel (0,0)
- frame_count  out  8  completed-frame counter; wraps 255->0

## Operation
- H_TOTAL = sum of the H parameters; V_TOTAL = sum of the V parameters. Defaults give 800 and 525.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt advances when h_cnt wraps and counts 0..V_TOTAL-1.
- Visible area: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- hsync is active for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; defaults give 656..751.
- vsync is active for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]; defaults give 490..491.
- End of frame (EOF) is h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
  - At EOF, mode_q <= mode and frame_count increments.
  - A mode change never takes effect mid-frame.
- Patterns, by mode_q. "White" is all ones; "black" is all zeros.
  - Mode 0, colour bars: 8 bars of H_VISIBLE/8 pixels, in the order white, yellow, cyan, green, magenta, red, blue, black. Bar index comes from a bar counter and bar-pixel counter, not a divider.
  - Mode 1, grid: white when x[4:0]=0, y[4:0]=0, x=H_VISIBLE-1 or y=V_VISIBLE-1; black otherwise.
  - Mode 2, gradient: red = x[COLOR_BITS-1:0], green = y[COLOR_BITS-1:0], blue = frame_count[7:8-COLOR_BITS].
  - Mode 3, checker: white when x[4]^y[4]^frame_count[5]=1, else black. The pattern inverts every 32 frames.
- Outside the visible area: rgb = 0, de = 0, x = 0, y = 0.
- Reset (including mid-frame), applied at the next edge:
  - h_cnt = v_cnt = 0, mode_q = 0, frame_count = 0.
  - rgb = 0, de = 0, x = y = 0, frame_start = 0.
  - hsync = ~HSYNC_POL and vsync = ~VSYNC_POL (inactive levels).

## Timing
- All outputs are registered. Outputs at edge n reflect the counter values held before edge n, so output latency from the counter state is 1 cycle. All outputs stay mutually aligned.
- The first edge with reset low produces the outputs for (0,0): de=1, frame_start=1, x=0, y=0.
- frame_count increments on the EOF edge. The outputs for the next frame's (0,0) on the following edge carry the new frame_count and the new mode.
- Line period = H_TOTAL cycles; frame period = H_TOTAL*V_TOTAL cycles (420000 at defaults). There are no bubbles or stalls.
- If reset and EOF coincide, reset wins: frame_count = 0 and mode_q = 0.

## Structure
- Package dvi_timing_pkg holds:
  - mode constants MODE_BARS = 0, MODE_GRID = 1, MODE_GRAD = 2, MODE_CHECK = 3
  - default 640x480@60 timing constants
  - the 8-entry colour-bar RGB table
- Sub-module dvi_timing_counter holds the h/v counters, visible/sync decode and EOF. It takes the same geometry parameters.
- The top level holds the pattern logic and output registers.
- Elaboration-time checks: H_VISIBLE%8 == 0 and 1 <= COLOR_BITS <= 8.

## Test plan
- Release reset and run one frame at defaults -> 800-cycle line period; hsync low exactly 96 cycles starting 656 cycles after de rises; vsync low on exactly 2 lines (490,491); 307200 de cycles per frame.
- Hold mode=0 -> at y=0, x=0..79 gives white (255,255,255), x=80 gives yellow (255,255,0), x=560..639 gives black.
- Change mode 0->1 mid-frame -> the current frame stays bars; the next frame shows the grid, with (0,5) white and (5,5) black.
- Run 256 frames -> frame_count wraps 255->0; frame_start pulses exactly once per frame, aligned with x=0,y=0,de=1.
- Assert reset mid-line (h=300,v=200) -> next cycle all outputs are at reset values with syncs inactive; after release, (0,0) appears first with frame_count=0.
- H_VISIBLE=800, V_VISIBLE=600, HSYNC_POL=1, COLOR_BITS=5, mode=2 -> hsync active-high; red = x[4:0]; rgb zero in blanking.
